frame_read_sequencer: RTL and testbench

- Drives the control port of the burst_read_wf Avalon-MM burst read master.
- Reads one frame of cfg_frame_words words from one of two frame buffers (ping-pong) by issuing consecutive bursts.
- A burst is issued only when the downstream read-data FIFO has room for the whole burst.
- Sits between the display/processing pipeline control and burst_read_wf.

---
 rtl/frame_rd_pkg.sv | 18 +
 rtl/frame_read_sequencer.sv | 128 ++++++++++++
 tb/tb_frame_read_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_rd_pkg.sv
// Shared definitions for the frame read sequencer.
// Holds the FSM state encoding and the default burst / FIFO sizing used as
// parameter defaults by frame_read_sequencer.
package frame_rd_pkg;

  localparam int FRD_BURST_COUNT = 8;    // max words per burst
  localparam int FRD_FIFO_DEPTH  = 512;  // downstream FIFO capacity in words

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    FINISH    = 3'd5
  } state_t;

endpackage

// File: rtl/frame_read_sequencer.sv
// frame_read_sequencer
// Reads one frame from one of two ping-pong frame buffers by issuing a series
// of bursts to the burst_read_wf control port. A burst is only issued when the
// downstream FIFO has room for all of it and the master is idle.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start, buf_sel    begin a frame (ignored unless idle), buffer select
//   abort             level; frame stops after the burst in flight
//   cfg_base0/1       byte base addresses of the two buffers
//   cfg_frame_words   frame length in words (0 = empty frame)
//   fifo_usedw        downstream FIFO fill level
//   ctrl_*            control port of burst_read_wf
//   busy, cur_buf     sequencer active, buffer being read
//   frame_done        one-cycle pulse, frame completed
//   frame_aborted     one-cycle pulse, frame terminated by abort
module frame_read_sequencer
  import frame_rd_pkg::*;
#(
  parameter int ADDRESS_WIDTH          = 32,
  parameter int LENGTH_WIDTH           = 24,
  parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
  parameter int BURST_COUNT            = FRD_BURST_COUNT,
  parameter int BURST_WIDTH            = 4,
  parameter int FIFO_DEPTH             = FRD_FIFO_DEPTH,
  parameter int FIFO_USEDW_WIDTH       = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        buf_sel,
  input  logic                        abort,
  input  logic [ADDRESS_WIDTH-1:0]    cfg_base0,
  input  logic [ADDRESS_WIDTH-1:0]    cfg_base1,
  input  logic [LENGTH_WIDTH-1:0]     cfg_frame_words,
  input  logic [FIFO_USEDW_WIDTH-1:0] fifo_usedw,
  output logic                        ctrl_start,
  output logic [ADDRESS_WIDTH-1:0]    ctrl_baseaddress,
  output logic [BURST_WIDTH-1:0]      ctrl_burstcount,
  input  logic                        ctrl_busy,
  output logic                        busy,
  output logic                        cur_buf,
  output logic                        frame_done,
  output logic                        frame_aborted
);

  // One extra bit so the free-space subtraction cannot wrap.
  localparam int FREE_W = FIFO_USEDW_WIDTH + 1;

  state_t                   state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [LENGTH_WIDTH-1:0]  remaining;
  logic                     aborted;
  logic [BURST_WIDTH-1:0]   len;
  logic [FREE_W-1:0]        free_words;
  logic                     room;
  logic                     last_burst;

  always_comb begin
    len        = (remaining >= LENGTH_WIDTH'(BURST_COUNT)) ? BURST_WIDTH'(BURST_COUNT)
                                                           : remaining[BURST_WIDTH-1:0];
    free_words = FREE_W'(FIFO_DEPTH) - {1'b0, fifo_usedw};
    // An over-reported fill level is treated as full rather than wrapping.
    room       = ({1'b0, fifo_usedw} <= FREE_W'(FIFO_DEPTH)) &&
                 (free_words >= FREE_W'(len));
    // The burst in flight carries the held length, so compare against that.
    last_burst = (remaining == LENGTH_WIDTH'(ctrl_burstcount));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (cfg_frame_words != '0) ? CHECK : FINISH;
      CHECK: begin
        if (abort)                   state_nxt = FINISH;
        else if (room && !ctrl_busy) state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (ctrl_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!ctrl_busy) state_nxt = last_burst ? FINISH : CHECK;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr             <= '0;
      remaining        <= '0;
      aborted          <= 1'b0;
      cur_buf          <= 1'b0;
      ctrl_baseaddress <= '0;
      ctrl_burstcount  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr      <= buf_sel ? cfg_base1 : cfg_base0;
          remaining <= cfg_frame_words;
          cur_buf   <= buf_sel;
          aborted   <= 1'b0;
        end
        CHECK: begin
          if (abort) aborted <= 1'b1;
          else if (room && !ctrl_busy) begin
            ctrl_baseaddress <= addr;
            ctrl_burstcount  <= len;
          end
        end
        WAIT_DONE: if (!ctrl_busy) begin
          addr      <= addr + (ADDRESS_WIDTH'(ctrl_burstcount) << BYTE_ENABLE_WIDTH_LOG2);
          remaining <= remaining - LENGTH_WIDTH'(ctrl_burstcount);
        end
        default: ;
      endcase
    end
  end

  assign ctrl_start    = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign frame_done    = (state == FINISH) && !aborted;
  assign frame_aborted = (state == FINISH) &&  aborted;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Self-checking bench for frame_read_sequencer. A behavioural burst_read_wf
// responder acks each ctrl_start after a random delay and stays busy for the
// burst plus slack; every issued burst is logged and compared against a burst
// list computed arithmetically from the frame length and base address.
module tb_frame_read_sequencer;

  localparam int AW = 32, LW = 24, BW = 4, UW = 10;
  localparam int BURST = 8, DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, buf_sel = 1'b0, abort = 1'b0;
  logic [AW-1:0] cfg_base0 = '0, cfg_base1 = '0;
  logic [LW-1:0] cfg_frame_words = '0;
  logic [UW-1:0] fifo_usedw = '0;
  logic          ctrl_start, ctrl_busy = 1'b0;
  logic [AW-1:0] ctrl_baseaddress;
  logic [BW-1:0] ctrl_burstcount;
  logic          busy, cur_buf, frame_done, frame_aborted;

  frame_read_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .buf_sel(buf_sel), .abort(abort),
    .cfg_base0(cfg_base0), .cfg_base1(cfg_base1), .cfg_frame_words(cfg_frame_words),
    .fifo_usedw(fifo_usedw), .ctrl_start(ctrl_start), .ctrl_baseaddress(ctrl_baseaddress),
    .ctrl_burstcount(ctrl_burstcount), .ctrl_busy(ctrl_busy), .busy(busy),
    .cur_buf(cur_buf), .frame_done(frame_done), .frame_aborted(frame_aborted)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / responder state
  int            cyc = 0;
  int            ack_cnt = 0, busy_cnt = 0;
  logic [AW-1:0] got_addr[$];
  int            got_len[$];
  int            done_cnt = 0, abort_cnt = 0;
  int            first_start_cyc = -1, done_cyc = -1;
  logic          done_buf = 1'b0;
  logic [UW-1:0] usedw_next = '0;
  bit            usedw_rand = 1'b0;
  bit            abort_arm = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  int            cur_len = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      ack_cnt = 0; busy_cnt = 0; ctrl_busy = 1'b0;
    end else begin
      if (ctrl_start) begin
        chk("one_outstanding", (ctrl_busy || ack_cnt > 0 || busy_cnt > 0), 0);
        chk("fifo_room", ((DEPTH - int'(fifo_usedw)) >= int'(ctrl_burstcount)), 1);
        got_addr.push_back(ctrl_baseaddress);
        got_len.push_back(int'(ctrl_burstcount));
        cur_addr = ctrl_baseaddress;
        cur_len  = int'(ctrl_burstcount);
        if (first_start_cyc < 0) first_start_cyc = cyc;
      end
      if (frame_done)    begin done_cnt++;  done_cyc = cyc; done_buf = cur_buf; end
      if (frame_aborted) begin abort_cnt++; done_cyc = cyc; done_buf = cur_buf; end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin ctrl_busy = 1'b1; busy_cnt = cur_len + $urandom_range(0, 3); end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          chk("hold_addr", ctrl_baseaddress, cur_addr);
          chk("hold_len", ctrl_burstcount, cur_len);
          ctrl_busy = 1'b0;
        end
      end
      if (ctrl_start) ack_cnt = $urandom_range(1, 3);
    end
    // Abort goes up once the second burst is in flight and stays until disarmed.
    abort = abort_arm && (abort || (got_len.size() == 2 && ctrl_busy));
    if (usedw_rand) begin
      if ($urandom_range(0, 3) == 0) fifo_usedw = UW'($urandom_range(0, DEPTH));
    end else fifo_usedw = usedw_next;
  end

  task automatic clear_log();
    got_addr.delete(); got_len.delete();
    done_cnt = 0; abort_cnt = 0; first_start_cyc = -1; done_cyc = -1;
  endtask

  task automatic run_frame(input int n, input bit sel, input bit do_abort,
                           input bit restart_mid, input bit chk_lat, input int hold);
    logic [AW-1:0] b, exp_addr[$];
    int            exp_len[$];
    int            st, t, off, l, nb;
    b = sel ? cfg_base1 : cfg_base0;
    off = 0;
    while (off < n) begin
      l = (n - off > BURST) ? BURST : n - off;
      exp_addr.push_back(b + AW'(off * 4));
      exp_len.push_back(l);
      off += l;
    end
    if (do_abort) while (exp_len.size() > 2) begin void'(exp_len.pop_back()); void'(exp_addr.pop_back()); end
    clear_log();
    abort_arm = do_abort;
    if (hold > 0) usedw_next = UW'(508);
    @(negedge clk); #1;
    cfg_frame_words = LW'(n); buf_sel = sel; start = 1'b1; st = cyc;
    @(negedge clk); #1;
    // Later config changes and a repeated start must not disturb the frame.
    start = restart_mid; buf_sel = ~sel;
    cfg_base0 = $urandom; cfg_base1 = $urandom; cfg_frame_words = LW'($urandom);
    if (restart_mid) begin @(negedge clk); #1; start = 1'b0; end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin @(negedge clk); #1; end
      chk("hold_no_issue", got_len.size(), 0);
      t = cyc; usedw_next = UW'(100);
    end
    for (int i = 0; i < 3000 && (done_cnt + abort_cnt) == 0; i++) begin @(negedge clk); #1; end
    chk("frame_end", done_cnt + abort_cnt, 1);
    @(negedge clk); #1;
    chk("busy_after", busy, 0);
    nb = got_len.size();
    for (int i = 0; i < 4; i++) begin @(negedge clk); #1; end
    chk("no_extra_burst", got_len.size(), nb);
    chk("nbursts", got_len.size(), exp_len.size());
    for (int i = 0; i < exp_len.size() && i < got_len.size(); i++) begin
      chk("burst_addr", got_addr[i], exp_addr[i]);
      chk("burst_len", got_len[i], exp_len[i]);
    end
    chk("done_cnt", done_cnt, do_abort ? 0 : 1);
    chk("abort_cnt", abort_cnt, do_abort ? 1 : 0);
    chk("cur_buf", done_buf, sel);
    if (chk_lat && n > 0) chk("issue_lat", first_start_cyc - st, 2);
    if (chk_lat && n == 0) chk("zero_done_lat", done_cyc - st, 1);
    if (hold > 0) chk("hold_release_lat", first_start_cyc - t, 2);
    abort_arm = 1'b0;
    usedw_next = '0;
    @(negedge clk); #1;
  endtask

  task automatic chk_outputs_zero();
    chk("rst_ctrl_start", ctrl_start, 0);
    chk("rst_ctrl_addr", ctrl_baseaddress, 0);
    chk("rst_ctrl_len", ctrl_burstcount, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_buf", cur_buf, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_aborted", frame_aborted, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 chk_outputs_zero();
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    cfg_base0 = 32'h3800_0000;
    run_frame(32, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    cfg_base1 = 32'h3810_0000;
    run_frame(19, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    cfg_base0 = 32'h3820_0000;
    run_frame(16, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    cfg_base1 = 32'h3830_0000;
    run_frame(32, 1'b1, 1'b1, 1'b0, 1'b1, 0);

    // Reset while the first burst waits for its ack.
    clear_log();
    cfg_base1 = 32'h3840_0000;
    @(negedge clk); #1;
    cfg_frame_words = LW'(32); buf_sel = 1'b1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    for (int i = 0; i < 50 && ack_cnt == 0; i++) begin @(negedge clk); #1; end
    chk("reached_wait_ack", (ack_cnt > 0), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1 chk_outputs_zero();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    chk("rst_no_pulse", done_cnt + abort_cnt, 0);
    cfg_base0 = 32'h3850_0000;
    run_frame(16, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    run_frame(0, 1'b1, 1'b0, 1'b0, 1'b1, 0);

    // Randomized frames with a wandering FIFO level; bases may wrap.
    usedw_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int  n;
      bit  s;
      n = $urandom_range(0, 60);
      s = 1'($urandom_range(0, 1));
      cfg_base0 = (k == 3) ? 32'hFFFF_FFF0 : $urandom;
      cfg_base1 = $urandom;
      run_frame(n, s, 1'b0, (n >= 9) && ($urandom_range(0, 1) == 1), 1'b0, 0);
    end
    usedw_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
